// File: rtl/ptw_walker_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ptw_walker_pkg : shared widths, FSM encodings and PTE layout for the walker
// Rev 1.0
// -----------------------------------------------------------------------------
package ptw_walker_pkg;

  localparam int PTW_VADDR_WIDTH = 32;
  localparam int PTW_PADDR_WIDTH = 32;
  localparam int PTW_DATA_WIDTH  = 32;
  localparam int PTW_LEVELS      = 2;
  localparam int PTW_VPN_BITS    = 10;
  localparam int PTW_OFFSET_BITS = 12;
  localparam int PTW_PTE_BYTES   = 4;
  localparam int PTW_PPN_BITS    = PTW_DATA_WIDTH - 10;

  typedef logic [1:0] ptw_state_e;
  localparam logic [1:0] PTW_IDLE = 2'd0;
  localparam logic [1:0] PTW_REQ  = 2'd1;
  localparam logic [1:0] PTW_WAIT = 2'd2;
  localparam logic [1:0] PTW_DONE = 2'd3;

  typedef struct packed {
    logic [PTW_PPN_BITS-1:0] ppn;
    logic [1:0]              rsw;
    logic                    d;
    logic                    a;
    logic                    g;
    logic                    u;
    logic                    x;
    logic                    w;
    logic                    r;
    logic                    v;
  } pte_t;

  function automatic logic pte_is_leaf(input pte_t pte);
    return pte.r | pte.w | pte.x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ptw_walker_pte_check.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ptw_pte_check : combinational PTE decoder (leaf / fault / misaligned superpage)
// Rev 1.0
// -----------------------------------------------------------------------------
module ptw_pte_check
  import ptw_walker_pkg::*;
#(
  parameter int VPN_BITS = PTW_VPN_BITS
) (
  input  pte_t       pte_i,
  input  logic [1:0] lvl_i,
  output logic       is_leaf_o,
  output logic       fault_o,
  output logic       misaligned_o
);

  logic [PTW_PPN_BITS-1:0] low_mask;
  logic                    unused_bits;

  assign is_leaf_o = pte_is_leaf(pte_i);
  assign fault_o   = !pte_i.v || (!pte_i.r && pte_i.w);

  // A leaf above the last level maps a superpage; its low PPN bits must be zero.
  assign low_mask     = ~({PTW_PPN_BITS{1'b1}} << (32'(lvl_i) * 32'(VPN_BITS)));
  assign misaligned_o = is_leaf_o && ((pte_i.ppn & low_mask) != '0);

  assign unused_bits = ^{pte_i.rsw, pte_i.d, pte_i.a, pte_i.g, pte_i.u};

endmodule
`default_nettype wire

// File: rtl/ptw_walker.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ptw_walker : multi-level radix page-table walker over a req/gnt/rvalid port
// Rev 1.0
// -----------------------------------------------------------------------------
module ptw_walker
  import ptw_walker_pkg::*;
#(
  parameter int VADDR_WIDTH = PTW_VADDR_WIDTH,
  parameter int PADDR_WIDTH = PTW_PADDR_WIDTH,
  parameter int DATA_WIDTH  = PTW_DATA_WIDTH,
  parameter int LEVELS      = PTW_LEVELS,
  parameter int VPN_BITS    = PTW_VPN_BITS,
  parameter int OFFSET_BITS = PTW_OFFSET_BITS,
  parameter int PTE_BYTES   = PTW_PTE_BYTES
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic [VADDR_WIDTH-1:0] vaddr_i,
  input  logic [DATA_WIDTH-1:0]  satp_data_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic                   error_o,
  output logic [PADDR_WIDTH-1:0] paddr_o,
  output logic [1:0]             level_o,
  output logic                   mem_req_o,
  output logic [PADDR_WIDTH-1:0] mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
  input  logic                   mem_err_i
);

  localparam int PPN_BITS  = DATA_WIDTH - 10;
  localparam int PTE_SHIFT = $clog2(PTE_BYTES);
  localparam int ADDR_FULL = PPN_BITS + VPN_BITS + PTE_SHIFT;
  localparam int ADDR_W    = (ADDR_FULL > PADDR_WIDTH) ? ADDR_FULL : PADDR_WIDTH;
  localparam int PA_FULL   = PPN_BITS + OFFSET_BITS;
  localparam int PA_W      = (PA_FULL > PADDR_WIDTH) ? PA_FULL : PADDR_WIDTH;

  ptw_state_e             state_q, state_d;
  logic [VADDR_WIDTH-1:0] vaddr_q, vaddr_d;
  logic [PPN_BITS-1:0]    ppn_q, ppn_d;
  logic [1:0]             lvl_q, lvl_d;
  logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                   error_q, error_d;
  logic [1:0]             level_q, level_d;

  pte_t                   pte;
  logic                   pte_leaf, pte_fault, pte_misaligned;
  logic [31:0]            vpn_shift;
  logic [VPN_BITS-1:0]    vpn;
  logic [ADDR_W-1:0]      pte_addr;
  logic [PA_W-1:0]        hi_mask, leaf_pa;
  logic                   descend, walk_ok;
  logic                   unused_bits;

  assign pte = mem_rdata_i;

  ptw_pte_check #(
    .VPN_BITS (VPN_BITS)
  ) u_pte_check (
    .pte_i        (pte),
    .lvl_i        (lvl_q),
    .is_leaf_o    (pte_leaf),
    .fault_o      (pte_fault),
    .misaligned_o (pte_misaligned)
  );

  // vpn_shift is both the VPN index position and the count of vaddr bits a leaf keeps.
  assign vpn_shift = 32'(OFFSET_BITS) + 32'(lvl_q) * 32'(VPN_BITS);
  assign vpn       = VPN_BITS'(vaddr_q >> vpn_shift);
  assign pte_addr  = ADDR_W'({ppn_q, vpn}) << PTE_SHIFT;
  assign hi_mask   = {PA_W{1'b1}} << vpn_shift;
  assign leaf_pa   = (PA_W'({pte.ppn, {OFFSET_BITS{1'b0}}}) & hi_mask)
                   | (PA_W'(vaddr_q) & ~hi_mask);

  assign descend = !mem_err_i && !pte_fault && !pte_leaf && (lvl_q != 2'd0);
  assign walk_ok = !mem_err_i && !pte_fault && pte_leaf && !pte_misaligned;

  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    ppn_d   = ppn_q;
    lvl_d   = lvl_q;
    paddr_d = paddr_q;
    error_d = error_q;
    level_d = level_q;
    case (state_q)
      PTW_IDLE: begin
        if (req_i) begin
          vaddr_d = vaddr_i;
          ppn_d   = satp_data_i[PPN_BITS-1:0];
          lvl_d   = 2'(LEVELS - 1);
          state_d = PTW_REQ;
        end
      end
      PTW_REQ: begin
        if (mem_gnt_i) state_d = PTW_WAIT;
      end
      PTW_WAIT: begin
        if (mem_rvalid_i) begin
          if (descend) begin
            ppn_d   = pte.ppn;
            lvl_d   = lvl_q - 2'd1;
            state_d = PTW_REQ;
          end else begin
            // Faulting walks keep the last good paddr on the output.
            error_d = !walk_ok;
            level_d = lvl_q;
            if (walk_ok) paddr_d = leaf_pa[PADDR_WIDTH-1:0];
            state_d = PTW_DONE;
          end
        end
      end
      PTW_DONE: state_d = PTW_IDLE;
      default:  state_d = PTW_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PTW_IDLE;
      vaddr_q <= '0;
      ppn_q   <= '0;
      lvl_q   <= '0;
      paddr_q <= '0;
      error_q <= 1'b0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      ppn_q   <= ppn_d;
      lvl_q   <= lvl_d;
      paddr_q <= paddr_d;
      error_q <= error_d;
      level_q <= level_d;
    end
  end

  assign ready_o    = (state_q == PTW_IDLE);
  assign valid_o    = (state_q == PTW_DONE);
  assign mem_req_o  = (state_q == PTW_REQ);
  assign mem_addr_o = mem_req_o ? pte_addr[PADDR_WIDTH-1:0] : '0;
  assign error_o    = error_q;
  assign paddr_o    = paddr_q;
  assign level_o    = level_q;

  assign unused_bits = ^{satp_data_i, pte_addr, leaf_pa};

endmodule
`default_nettype wire
